// File: rtl/counter_tick_pkg.sv
// rtl/counter_tick_pkg.sv - shared types for the counter tick controller (optional COUNTER_TICK_PWM_EN)
package counter_tick_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEFAULT_WIDTH = 26;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] period;
    logic                     oneshot;
`ifdef COUNTER_TICK_PWM_EN
    logic [DEFAULT_WIDTH-1:0] duty;
`endif
  } cfg_t;

endpackage

// File: rtl/counter_tick_shadow.sv
// rtl/counter_tick_shadow.sv - active config register with shadow/pending path (optional COUNTER_TICK_PWM_EN)
module counter_tick_shadow
  import counter_tick_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PERIOD = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_oneshot_i,
`ifdef COUNTER_TICK_PWM_EN
  input  logic [WIDTH-1:0] cfg_duty_i,
  output logic [WIDTH-1:0] duty_o,
  output logic [WIDTH-1:0] duty_nxt_o,
`endif
  input  logic             running_i,
  input  logic             apply_i,
  output logic [WIDTH-1:0] period_o,
  output logic             oneshot_o
);

  typedef struct packed {
    logic [WIDTH-1:0] period;
    logic             oneshot;
`ifdef COUNTER_TICK_PWM_EN
    logic [WIDTH-1:0] duty;
`endif
  } cfg_w_t;

  cfg_w_t active_q, active_d;
  cfg_w_t shadow_q, shadow_d;
  cfg_w_t incoming, reset_cfg;
  logic   pending_q, pending_d;
  logic   accept;

  always_comb begin
    reset_cfg        = '0;
    reset_cfg.period = RESET_PERIOD;
    incoming         = '0;
    incoming.period  = cfg_period_i;
    incoming.oneshot = cfg_oneshot_i;
`ifdef COUNTER_TICK_PWM_EN
    incoming.duty    = cfg_duty_i;
`endif
  end

  assign accept = cfg_valid_i && !pending_q;

  // Outside RUN a leftover shadow (captured on a stop or one-shot wrap) is flushed at once.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (!running_i) begin
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end else if (accept) begin
        active_d = incoming;
      end
    end else begin
      if (apply_i && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (accept) begin
        shadow_d  = incoming;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q  <= reset_cfg;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign cfg_ready_o = !pending_q;
  assign period_o    = active_q.period;
  assign oneshot_o   = active_q.oneshot;
`ifdef COUNTER_TICK_PWM_EN
  assign duty_o      = active_q.duty;
  assign duty_nxt_o  = active_d.duty;
`endif

endmodule

// File: rtl/counter_tick_ctrl.sv
// rtl/counter_tick_ctrl.sv - start/stop counter FSM with terminal-count tick and LED toggle (optional COUNTER_TICK_PWM_EN)
module counter_tick_ctrl
  import counter_tick_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PERIOD = 26'h2FA_F07F
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
`ifdef COUNTER_TICK_PWM_EN
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm,
`endif
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             led
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             led_q, led_d;
  logic [WIDTH-1:0] period_act;
  logic             oneshot_act;
  logic             running, at_term, apply;

  assign running = (state_q == RUN);
  assign at_term = (count_q == period_act);
  assign apply   = running && (at_term || stop);

`ifdef COUNTER_TICK_PWM_EN
  logic [WIDTH-1:0] duty_act, duty_nxt;
  logic             pwm_q, pwm_d;
`endif

  counter_tick_shadow #(
    .WIDTH        (WIDTH),
    .RESET_PERIOD (RESET_PERIOD)
  ) u_shadow (
    .clk_i         (CLK),
    .rst_i         (RESET),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_period_i  (cfg_period),
    .cfg_oneshot_i (cfg_oneshot),
`ifdef COUNTER_TICK_PWM_EN
    .cfg_duty_i    (cfg_duty),
    .duty_o        (duty_act),
    .duty_nxt_o    (duty_nxt),
`endif
    .running_i     (running),
    .apply_i       (apply),
    .period_o      (period_act),
    .oneshot_o     (oneshot_act)
  );

  // stop outranks start and the terminal-count wrap.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        count_d = '0;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (at_term) begin
          count_d = '0;
          tick_d  = 1'b1;
          if (oneshot_act) state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    led_d = led_q ^ tick_d;
  end

`ifdef COUNTER_TICK_PWM_EN
  // Compared against next-cycle count/duty so pwm lines up with the count it describes.
  always_comb begin
    pwm_d = (state_d == RUN) && (count_d < duty_nxt);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pwm_q <= 1'b0;
    else       pwm_q <= pwm_d;
  end

  assign pwm = pwm_q;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign busy  = running;
  assign led   = led_q;

endmodule

// File: doc/counter_tick_ctrl.md
Name: counter_tick_ctrl

Overview:
- Sequencing controller for an N-bit free-running counter/register pair: start/stop, programmable terminal count, periodic or one-shot mode.
- Emits a one-cycle tick at each terminal count and toggles an LED output on every tick.
- Sits between the PLL-clocked fabric and board LEDs / downstream periodic consumers.
- Replaces hard-wired "use counter MSB as LED" with a configurable rate.

Parameters:
- WIDTH, 26, counter and period width in bits.
- RESET_PERIOD, 26'h2FA_F07F, period register value loaded at reset (WIDTH bits).

Ports:
- CLK  in  1  system clock (PLL global output).
- RESET  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept; transfer when cfg_valid & cfg_ready.
- cfg_period  in  WIDTH  terminal count; the tick interval is cfg_period+1 cycles.
- cfg_oneshot  in  1  1 = stop after the first tick; 0 = periodic.
- start  in  1  level-sampled start request.
- stop  in  1  level-sampled stop request.
- count  out  WIDTH  current counter value.
- tick  out  1  registered pulse, high for one cycle when count==period.
- busy  out  1  high while in RUN.
- led  out  1  toggles on every tick.

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-high on RESET.
- Reset values:
  - state=IDLE, count=0, tick=0, busy=0, led=0, cfg_ready=1.
  - period=RESET_PERIOD, oneshot=0, shadow_pending=0.
- States:
  - IDLE: count held at 0. start -> RUN next cycle.
  - RUN: count increments by 1 per cycle. When count==period: count->0 and tick=1 in the following cycle (registered, 1-cycle latency). If oneshot -> DONE.
  - DONE: count=0, busy=0. start -> RUN. cfg accepted as in IDLE.
- stop:
  - In RUN -> IDLE next cycle, count cleared, no tick issued.
  - stop and start in the same cycle: stop wins.
  - stop in IDLE/DONE: no effect.
- Config handshake:
  - In IDLE/DONE, cfg_ready=1 and an accepted cfg writes period/oneshot directly.
  - In RUN, an accepted cfg goes into a shadow register. shadow_pending=1 forces cfg_ready=0.
  - The shadow is applied on the wrap cycle (count==period), so a new period takes effect from the next interval. shadow_pending then clears; cfg_ready=1 the following cycle.
  - A cfg accepted in the same cycle as a wrap goes to the shadow and applies at the next wrap.
  - A config handshake never stalls counting.
- Arithmetic/width rules:
  - count is unsigned WIDTH bits.
  - period=0 gives a tick every cycle while in RUN; led toggles every cycle.
  - period=2^WIDTH-1 gives a full-range wrap, no overflow beyond the natural wrap.
  - The comparison uses the active period only, never the shadow.
- led toggles only on tick. It is held in IDLE/DONE and not cleared by stop.
- RESET mid-RUN returns everything to reset values immediately; a pending shadow is discarded.

Optional Feature:
- Macro: COUNTER_TICK_PWM_EN.
- When defined:
  - Extra input cfg_duty (WIDTH) is captured with cfg_period through the same shadow path.
  - Extra output pwm (registered) is 1 while in RUN and count < duty, otherwise 0.
  - duty > period gives constant 1; duty=0 gives constant 0.
- When undefined: no cfg_duty/pwm ports and no duty register.

Decomposition:
- Shared package counter_tick_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparam DEFAULT_WIDTH=26.
  - cfg struct {period, oneshot[, duty]}.
- One sub-module, counter_tick_shadow: holds the cfg register plus the shadow/pending logic and drives cfg_ready. The top level holds the FSM and counter.

Test Plan:
- Reset, then cfg period=3 periodic, start -> tick on cycles 4,8,12 after RUN entry; led toggles 0->1->0->1; count sequence 0,1,2,3,0.
- cfg period=5 oneshot, start -> single tick 6 cycles after RUN entry, then DONE with busy=0 and count=0; restart via start repeats.
- RUN with period=7, cfg period=2 offered mid-interval -> cfg_ready drops, old 8-cycle interval completes, next intervals 3 cycles; second cfg while pending is not accepted until after the wrap.
- start and stop asserted together in RUN -> IDLE, count=0, no tick. RESET asserted mid-count (count=4) -> count=0, led=0, period=RESET_PERIOD asynchronously.
- period=0 -> tick high every cycle in RUN, led toggles every cycle. period=all-ones with WIDTH=4 -> tick every 16 cycles.
- With COUNTER_TICK_PWM_EN: period=9, duty=3 -> pwm high for counts 0..2, low for 3..9. duty=12 -> pwm constant 1.
